// File: rtl/pong_graph_pipe.sv
// Two-stage pong pixel renderer: wall, NUM_PADDLES paddles and a ball, with frame-latched
// positions and per-frame ball overlap reporting. Define PONG_ROUND_BALL_EN for a round ball.
module pong_graph_pipe #(
    parameter int unsigned      COORD_W     = 10,
    parameter int unsigned      MAX_X       = 640,
    parameter int unsigned      MAX_Y       = 480,
    parameter int unsigned      WALL_SIZE   = 16,
    parameter int unsigned      NUM_PADDLES = 2,
    parameter int unsigned      PADDLE_W    = 16,
    parameter int unsigned      PADDLE_H    = 64,
    parameter int unsigned      BALL_SIZE   = 16,
    parameter int unsigned      RGB_W       = 3,
    parameter logic [RGB_W-1:0] WALL_RGB    = 3'b001,
    parameter logic [RGB_W-1:0] PADDLE_RGB  = 3'b010,
    parameter logic [RGB_W-1:0] BALL_RGB    = 3'b100,
    parameter logic [RGB_W-1:0] BG_RGB      = 3'b110
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           video_on,
    input  logic [COORD_W-1:0]             pix_x,
    input  logic [COORD_W-1:0]             pix_y,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             ball_x,
    input  logic [COORD_W-1:0]             ball_y,
    input  logic [NUM_PADDLES*COORD_W-1:0] paddle_x,
    input  logic [NUM_PADDLES*COORD_W-1:0] paddle_y,
    output logic [RGB_W-1:0]               graph_rgb,
    output logic [NUM_PADDLES-1:0]         hit_paddle,
    output logic                           hit_wall,
    output logic                           hit_valid
);

    localparam logic [COORD_W-1:0] WALL_LO_C = COORD_W'(WALL_SIZE);
    localparam logic [COORD_W-1:0] WALL_HI_C = COORD_W'(MAX_Y - WALL_SIZE);
    localparam logic [COORD_W:0]   PAD_W_C   = (COORD_W+1)'(PADDLE_W);
    localparam logic [COORD_W:0]   PAD_H_C   = (COORD_W+1)'(PADDLE_H);
    localparam logic [COORD_W:0]   BALL_C    = (COORD_W+1)'(BALL_SIZE);

    // Extra bit on the upper bound keeps objects near 2^COORD_W from wrapping to small values.
    function automatic logic in_span(input logic [COORD_W-1:0] p,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W:0]   len);
        return (p >= lo) && ({1'b0, p} < ({1'b0, lo} + len));
    endfunction

    // Shadow positions, loaded once per frame
    logic [COORD_W-1:0]             ball_x_q, ball_y_q;
    logic [NUM_PADDLES*COORD_W-1:0] paddle_x_q, paddle_y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_x_q   <= '0;
            ball_y_q   <= '0;
            paddle_x_q <= '0;
            paddle_y_q <= '0;
        end else if (frame_tick) begin
            ball_x_q   <= ball_x;
            ball_y_q   <= ball_y;
            paddle_x_q <= paddle_x;
            paddle_y_q <= paddle_y;
        end
    end

    // Stage 1: object hit tests
    logic                   wall_d;
    logic [NUM_PADDLES-1:0] paddle_d;
    logic                   ball_box;
    logic                   ball_d;

    always_comb begin
        wall_d   = (pix_x < WALL_LO_C) || (pix_y < WALL_LO_C) || (pix_y >= WALL_HI_C);
        paddle_d = '0;
        for (int i = 0; i < int'(NUM_PADDLES); i++) begin
            paddle_d[i] = in_span(pix_x, paddle_x_q[i*COORD_W +: COORD_W], PAD_W_C) &&
                          in_span(pix_y, paddle_y_q[i*COORD_W +: COORD_W], PAD_H_C);
        end
        ball_box = in_span(pix_x, ball_x_q, BALL_C) && in_span(pix_y, ball_y_q, BALL_C);
    end

`ifdef PONG_ROUND_BALL_EN
    localparam int unsigned BALL_SH = $clog2(BALL_SIZE / 8);

    // Offset inside the ball, scaled down to the 8x8 bitmap grid
    function automatic logic [2:0] rom_idx(input logic [COORD_W-1:0] p,
                                           input logic [COORD_W-1:0] origin);
        logic [COORD_W-1:0] d;
        d = p - origin;
        return d[BALL_SH +: 3];
    endfunction

    logic [2:0] ball_row;
    logic [2:0] ball_col;
    logic [7:0] rom_bits;

    assign ball_row = rom_idx(pix_y, ball_y_q);
    assign ball_col = rom_idx(pix_x, ball_x_q);

    always_comb begin
        rom_bits = 8'hFF;
        case (ball_row)
            3'd0, 3'd7: rom_bits = 8'b0011_1100;
            3'd1, 3'd6: rom_bits = 8'b0111_1110;
            default:    rom_bits = 8'hFF;
        endcase
    end

    // Column 0 is the MSB of each bitmap row
    assign ball_d = ball_box && rom_bits[~ball_col];
`else
    assign ball_d = ball_box;
`endif

    logic                   wall_s1_q;
    logic [NUM_PADDLES-1:0] paddle_s1_q;
    logic                   ball_s1_q;
    logic                   video_s1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wall_s1_q   <= 1'b0;
            paddle_s1_q <= '0;
            ball_s1_q   <= 1'b0;
            video_s1_q  <= 1'b0;
        end else begin
            wall_s1_q   <= wall_d;
            paddle_s1_q <= paddle_d;
            ball_s1_q   <= ball_d;
            video_s1_q  <= video_on;
        end
    end

    // Stage 2: priority colour select
    logic [RGB_W-1:0] rgb_d;

    always_comb begin
        rgb_d = BG_RGB;
        if (!video_s1_q) begin
            rgb_d = '0;
        end else if (wall_s1_q) begin
            rgb_d = WALL_RGB;
        end else if (|paddle_s1_q) begin
            rgb_d = PADDLE_RGB;
        end else if (ball_s1_q) begin
            rgb_d = BALL_RGB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            graph_rgb <= '0;
        end else begin
            graph_rgb <= rgb_d;
        end
    end

    // Overlap accumulation; the term seen on a frame_tick cycle belongs to the new frame
    logic [NUM_PADDLES-1:0] ov_paddle;
    logic                   ov_wall;
    logic [NUM_PADDLES-1:0] acc_paddle_q;
    logic                   acc_wall_q;

    assign ov_paddle = paddle_s1_q & {NUM_PADDLES{ball_s1_q & video_s1_q}};
    assign ov_wall   = ball_s1_q & wall_s1_q & video_s1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_paddle_q <= '0;
            acc_wall_q   <= 1'b0;
            hit_paddle   <= '0;
            hit_wall     <= 1'b0;
            hit_valid    <= 1'b0;
        end else if (frame_tick) begin
            hit_paddle   <= acc_paddle_q;
            hit_wall     <= acc_wall_q;
            hit_valid    <= 1'b1;
            acc_paddle_q <= ov_paddle;
            acc_wall_q   <= ov_wall;
        end else begin
            hit_valid    <= 1'b0;
            acc_paddle_q <= acc_paddle_q | ov_paddle;
            acc_wall_q   <= acc_wall_q | ov_wall;
        end
    end

endmodule

// File: tb/tb_pong_graph_pipe.sv
// Scoreboard bench for pong_graph_pipe: the driver queues expected pixels and publishes,
// a negedge monitor pops and compares them.
module tb_pong_graph_pipe;

    localparam int unsigned CW = 10;
    localparam int unsigned NP = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           video_on = 1'b0;
    logic [CW-1:0]  pix_x = '0;
    logic [CW-1:0]  pix_y = '0;
    logic           frame_tick = 1'b0;
    logic [CW-1:0]  ball_x = '0;
    logic [CW-1:0]  ball_y = '0;
    logic [NP*CW-1:0] paddle_x = '0;
    logic [NP*CW-1:0] paddle_y = '0;
    logic [2:0]     graph_rgb;
    logic [NP-1:0]  hit_paddle;
    logic           hit_wall;
    logic           hit_valid;

    pong_graph_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_x   (paddle_x),
        .paddle_y   (paddle_y),
        .graph_rgb  (graph_rgb),
        .hit_paddle (hit_paddle),
        .hit_wall   (hit_wall),
        .hit_valid  (hit_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [2:0] rgb; } pix_exp_t;
    typedef struct { logic [NP-1:0] hp; logic hw; } hit_exp_t;

    pix_exp_t pix_q[$];
    hit_exp_t hit_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // Monitor
    always @(negedge clk) begin
        pix_exp_t e;
        hit_exp_t h;
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            e = pix_q.pop_front();
            n_vec++;
            if (e.due != cyc || graph_rgb !== e.rgb) begin
                n_bad++;
                $display("FAIL rgb cyc=%0d: got %b want %b (due %0d)", cyc, graph_rgb, e.rgb,
                         e.due);
            end
        end
        if (hit_valid === 1'b1) begin
            n_vec++;
            if (hit_q.size() == 0) begin
                n_bad++;
                $display("FAIL hit_valid cyc=%0d: got pulse want none", cyc);
            end else begin
                h = hit_q.pop_front();
                if (hit_paddle !== h.hp || hit_wall !== h.hw) begin
                    n_bad++;
                    $display("FAIL hit cyc=%0d: got paddle=%b wall=%b want paddle=%b wall=%b",
                             cyc, hit_paddle, hit_wall, h.hp, h.hw);
                end
            end
        end
    end

    task automatic drive(input logic vo, input int x, input int y, input logic ft,
                         input logic [2:0] exp);
        @(posedge clk);
        #1;
        video_on   = vo;
        pix_x      = CW'(x);
        pix_y      = CW'(y);
        frame_tick = ft;
        pix_q.push_back('{due: cyc + 2, rgb: exp});
    endtask

    task automatic tick(input logic [NP-1:0] hp, input logic hw);
        hit_q.push_back('{hp: hp, hw: hw});
        drive(1'b0, 0, 0, 1'b1, 3'b000);
    endtask

    task automatic set_pos(input int p0x, input int p0y, input int p1x, input int p1y,
                           input int bx, input int by);
        paddle_x = {CW'(p1x), CW'(p0x)};
        paddle_y = {CW'(p1y), CW'(p0y)};
        ball_x   = CW'(bx);
        ball_y   = CW'(by);
    endtask

    initial begin
        // Reset with a visible pixel applied
        repeat (3) begin
            @(posedge clk);
            #1;
            video_on = 1'b1;
            pix_x    = CW'(100);
            pix_y    = CW'(100);
            @(negedge clk);
            n_vec++;
            if ({graph_rgb, hit_paddle, hit_wall, hit_valid} !== '0) begin
                n_bad++;
                $display("FAIL reset: got rgb=%b hp=%b hw=%b hv=%b want all 0", graph_rgb,
                         hit_paddle, hit_wall, hit_valid);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        pix_q.push_back('{due: cyc + 1, rgb: 3'b000});
        pix_q.push_back('{due: cyc + 2, rgb: 3'b110});

        // Priority
        set_pos(16, 16, 300, 200, 20, 20);
        tick(2'b00, 1'b0);
        drive(1'b1, 5, 200, 1'b0, 3'b001);
        drive(1'b1, 18, 18, 1'b0, 3'b010);
        drive(1'b1, 30, 30, 1'b0, 3'b010);
        drive(1'b1, 100, 100, 1'b0, 3'b110);

        // Upper-bound wrap; previous frame had ball over paddle0
        set_pos(16, 16, 1020, 0, 20, 20);
        tick(2'b01, 1'b0);
        drive(1'b1, 4, 20, 1'b0, 3'b001);
        drive(1'b1, 1019, 20, 1'b0, 3'b110);
        drive(1'b1, 1023, 20, 1'b0, 3'b010);
        drive(1'b0, 1023, 20, 1'b0, 3'b000);

        // Ball over paddle1 for one frame
        set_pos(16, 16, 300, 200, 310, 210);
        tick(2'b00, 1'b0);
        drive(1'b1, 315, 215, 1'b0, 3'b010);
        drive(1'b1, 100, 100, 1'b0, 3'b110);
        set_pos(16, 16, 300, 200, 100, 100);
        tick(2'b10, 1'b0);
        drive(1'b1, 105, 105, 1'b0, 3'b100);

        // Overlap on the last pixel, coincident with frame_tick
        set_pos(96, 96, 300, 200, 100, 100);
        tick(2'b00, 1'b0);
        drive(1'b1, 50, 50, 1'b0, 3'b110);
        drive(1'b1, 105, 105, 1'b0, 3'b010);
        set_pos(16, 16, 300, 200, 100, 100);
        tick(2'b00, 1'b0);

        // Frame latch: ball_x input moves mid-frame
        drive(1'b1, 200, 200, 1'b0, 3'b110);
        ball_x = CW'(300);
        drive(1'b1, 105, 105, 1'b0, 3'b100);
        drive(1'b1, 305, 105, 1'b0, 3'b110);
        tick(2'b01, 1'b0);
        drive(1'b1, 305, 105, 1'b0, 3'b100);
        drive(1'b1, 105, 105, 1'b0, 3'b110);

        // Ball/wall overlap, then back-to-back ticks
        set_pos(16, 16, 300, 200, 8, 200);
        tick(2'b00, 1'b0);
        drive(1'b1, 10, 205, 1'b0, 3'b001);
        drive(1'b0, 0, 0, 1'b0, 3'b000);
        tick(2'b00, 1'b1);
        set_pos(16, 16, 300, 200, 200, 200);
        tick(2'b00, 1'b0);

        // Ball corner and centre
`ifdef PONG_ROUND_BALL_EN
        drive(1'b1, 200, 200, 1'b0, 3'b110);
`else
        drive(1'b1, 200, 200, 1'b0, 3'b100);
`endif
        drive(1'b1, 207, 207, 1'b0, 3'b100);
        drive(1'b0, 0, 0, 1'b0, 3'b000);

        repeat (4) @(negedge clk);
        while (pix_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rgb drain: got no sample want %b at cyc %0d", pix_q[0].rgb,
                     pix_q[0].due);
            void'(pix_q.pop_front());
        end
        while (hit_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL hit_valid missing: got none want pulse paddle=%b wall=%b",
                     hit_q[0].hp, hit_q[0].hw);
            void'(hit_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pong_graph_pipe.md
# pong_graph_pipe

Pipelined, parametrised pixel renderer for the pong display path. Draws the wall, `NUM_PADDLES` paddles and one ball, with per-frame latched object positions and a registered two-stage output. It also reports ball/paddle and ball/wall pixel overlap once per frame. It sits between the VGA sync generator and the RGB output register, and replaces the single-paddle combinational renderer.

## Interface
Parameters:
- `COORD_W`, 10: width of every x/y coordinate.
- `MAX_X`, 640: visible width.
- `MAX_Y`, 480: visible height.
- `WALL_SIZE`, 16: wall thickness on the left, top and bottom edges.
- `NUM_PADDLES`, 2: number of paddles, from 1 to 4.
- `PADDLE_W`, 16: paddle width.
- `PADDLE_H`, 64: paddle height.
- `BALL_SIZE`, 16: ball side length; must be a power of two and at least 8.
- `RGB_W`, 3: colour width.
- `WALL_RGB`, 3'b001; `PADDLE_RGB`, 3'b010; `BALL_RGB`, 3'b100; `BG_RGB`, 3'b110: object colours.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high.
- `video_on`  in  1  visible-area flag, aligned with `pix_x`/`pix_y`.
- `pix_x`, `pix_y`  in  COORD_W  current pixel.
- `frame_tick`  in  1  one-cycle pulse at start of frame.
- `ball_x`, `ball_y`  in  COORD_W  ball top-left corner.
- `paddle_x`, `paddle_y`  in  NUM_PADDLES*COORD_W  paddle top-left corners; paddle i is at `[i*COORD_W +: COORD_W]`.
- `graph_rgb`  out  RGB_W  pixel colour, 2 cycles after its pixel.
- `hit_paddle`  out  NUM_PADDLES  per-paddle overlap flags for the previous frame.
- `hit_wall`  out  1  ball/wall overlap flag for the previous frame.
- `hit_valid`  out  1  one-cycle pulse when `hit_*` update.

## Operation
- **Shadow registers.** Shadow copies of `ball_x`/`ball_y` and all paddle positions load on every clock edge where `frame_tick=1`. Rendering always uses the shadow copies, so objects never tear mid-frame.
- **Stage 1 (registered).** Computes:
  - `wall_on = pix_x<WALL_SIZE | pix_y<WALL_SIZE | pix_y>=MAX_Y-WALL_SIZE`
  - `paddle_on[i]` and `ball_on`: inclusive lower bound, exclusive upper bound.
  - Upper-bound sums are formed in COORD_W+1 bits, so a position near `2^COORD_W` never wraps to a small value.
  - `video_on` is delayed alongside these flags.
- **Stage 2 (registered).** Selects the colour by priority: blank (`video_on`=0 gives all zeros), then wall, then any paddle, then ball, then `BG_RGB`.
- **Overlap accumulation.** Uses stage-1 flags qualified by the delayed `video_on`:
  - `acc_paddle[i] |= ball_on & paddle_on[i]`
  - `acc_wall |= ball_on & wall_on`
- **Publish on `frame_tick`.**
  - `hit_paddle`/`hit_wall` take the accumulator values.
  - The accumulators reload with only the current cycle's overlap term, which belongs to the new frame.
  - `hit_valid` pulses high in the next cycle.
- **Simultaneous events.** Overlap and `frame_tick` in the same cycle: the overlap counts toward the new frame, never the published one.

## Timing
- Reset values: `graph_rgb`=0, `hit_paddle`=0, `hit_wall`=0, `hit_valid`=0, all shadow registers and accumulators 0, pipeline `video_on` 0.
- Latency: a pixel presented in cycle n appears on `graph_rgb` in cycle n+2. Throughput is one pixel per clock with no stalls.
- `hit_*` change only on the edge after `frame_tick` and hold for the whole frame.
- Shadow positions written at edge k are used for pixels presented from cycle k+1 onward.
- Reset asserted mid-frame clears everything immediately. After release, output is blank until two valid cycles have passed.
- Back-to-back `frame_tick` pulses: each pulse publishes and clears. A frame with no overlap publishes 0.

## Configuration
- Macro: `PONG_ROUND_BALL_EN`.
- Defined:
  - `ball_on` is further qualified by an 8x8 circular bitmap ROM (rows 0/7 = 8'b00111100, rows 1/6 = 8'b01111110, rows 2-5 = 8'hFF).
  - The ROM is indexed by `(pix_y-ball_y)` and `(pix_x-ball_x)` shifted right by log2(BALL_SIZE/8).
  - The ROM lookup is inside stage 1, so latency is still 2.
  - Overlap detection uses the masked shape.
- Undefined: the ball is a full BALL_SIZE square. No ROM is instantiated.

## Test plan
- **Reset and blanking.** Hold `reset` for 3 cycles with `video_on`=1 and (`pix_x`,`pix_y`)=(100,100) → `graph_rgb`=0 and all `hit_*`=0. After release, `graph_rgb`=3'b110 appears exactly 2 cycles after the first valid pixel.
- **Priority.** Set paddle0=(16,16) and ball=(20,20), then drive pixels (5,200), (18,18), (30,30), (100,100) → after 2 cycles each, `graph_rgb` = 001, 010, 010, 110 respectively.
- **Upper-bound wrap.** Set paddle1=(1020,0) and drive `pix_x`=4 → not paddle (no COORD_W wrap). `pix_x`=1019 → not paddle. `pix_x`=1023 at `pix_y`=20 → paddle, provided `video_on`=1.
- **Frame latch.** Change `ball_x` from 100 to 300 mid-frame → the ball still renders at 100 until after the next `frame_tick`.
- **Collision reporting.** Place the ball overlapping paddle1 for one frame, then clear of everything for the next frame:
  - After the first `frame_tick`: `hit_valid` pulses, `hit_paddle`=2'b10, `hit_wall`=0.
  - After the second `frame_tick`: `hit_paddle`=0.
  - An overlap coincident with `frame_tick` appears only in the following publish.
- **Round ball.** With `PONG_ROUND_BALL_EN` defined, ball=(200,200), BALL_SIZE=16: pixel (200,200) → background; pixel (207,207) → ball colour.
